// File: rtl/sha1_msg_padder.sv
// SHA-1 message padder: passes the AXIS message through and appends 0x80, zero fill
// and the 64-bit big-endian bit length so the output is a whole number of 512-bit blocks.
module sha1_msg_padder #(
    parameter int WIDTH     = 32,
    parameter int BLK_WORDS = 16,
    parameter int CNT_W     = 61
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             tvalid_s,
    input  logic [WIDTH-1:0] tdata_s,
    input  logic [3:0]       tkeep_s,
    input  logic             tlast_s,
    output logic             tready_s,
    output logic             tvalid_m,
    output logic [WIDTH-1:0] tdata_m,
    output logic             tlast_m,
    input  logic             tready_m,
    output logic             o_busy
);

    typedef enum logic [2:0] {
        S_DATA,
        S_PAD80,
        S_ZERO,
        S_LEN_HI,
        S_LEN_LO
    } state_t;

    // Last pad/zero word must be the one at this index so the length lands at 14/15.
    localparam logic [3:0] IDX_PRE_LEN = 4'(BLK_WORDS - 3);

    state_t           state, state_nxt;
    logic [3:0]       word_idx;
    logic [CNT_W-1:0] byte_cnt, byte_cnt_nxt;
    logic [2:0]       keep_cnt;
    logic [63:0]      bit_len;
    logic             in_hs;
    logic             out_hs;

    assign keep_cnt = {2'b00, tkeep_s[3]} + {2'b00, tkeep_s[2]}
                    + {2'b00, tkeep_s[1]} + {2'b00, tkeep_s[0]};
    assign bit_len  = 64'({byte_cnt, 3'b000});
    assign in_hs    = (state == S_DATA) && tvalid_s && tready_m && !i_rst;
    assign out_hs   = tvalid_m && tready_m;

    always_comb begin
        state_nxt    = state;
        byte_cnt_nxt = byte_cnt;
        tready_s     = 1'b0;
        tvalid_m     = 1'b0;
        tdata_m      = '0;
        tlast_m      = 1'b0;
        unique case (state)
            S_DATA: begin
                tready_s = tready_m;
                tvalid_m = tvalid_s;
                tdata_m  = tdata_s;
                if (tlast_s) begin
                    case (keep_cnt)
                        3'd0:    tvalid_m = 1'b0;
                        3'd1:    tdata_m  = {tdata_s[31:24], 8'h80, 16'h0000};
                        3'd2:    tdata_m  = {tdata_s[31:16], 8'h80, 8'h00};
                        3'd3:    tdata_m  = {tdata_s[31:8], 8'h80};
                        default: tdata_m  = tdata_s;
                    endcase
                end
                if (tvalid_s && tready_m) begin
                    if (!tlast_s) begin
                        byte_cnt_nxt = byte_cnt + CNT_W'(4);
                    end else begin
                        byte_cnt_nxt = byte_cnt + CNT_W'(keep_cnt);
                        if (keep_cnt == 3'd0 || keep_cnt == 3'd4)
                            state_nxt = S_PAD80;
                        else if (word_idx == IDX_PRE_LEN)
                            state_nxt = S_LEN_HI;
                        else
                            state_nxt = S_ZERO;
                    end
                end
            end
            S_PAD80: begin
                tvalid_m = 1'b1;
                tdata_m  = 32'h8000_0000;
                if (tready_m)
                    state_nxt = (word_idx == IDX_PRE_LEN) ? S_LEN_HI : S_ZERO;
            end
            S_ZERO: begin
                tvalid_m = 1'b1;
                if (tready_m && word_idx == IDX_PRE_LEN)
                    state_nxt = S_LEN_HI;
            end
            S_LEN_HI: begin
                tvalid_m = 1'b1;
                tdata_m  = bit_len[63:32];
                if (tready_m)
                    state_nxt = S_LEN_LO;
            end
            S_LEN_LO: begin
                tvalid_m = 1'b1;
                tdata_m  = bit_len[31:0];
                tlast_m  = 1'b1;
                if (tready_m) begin
                    state_nxt    = S_DATA;
                    byte_cnt_nxt = '0;
                end
            end
            default: state_nxt = S_DATA;
        endcase
        if (i_rst) begin
            tready_s = 1'b0;
            tvalid_m = 1'b0;
            tlast_m  = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= S_DATA;
            word_idx <= '0;
            byte_cnt <= '0;
            o_busy   <= 1'b0;
        end else begin
            state    <= state_nxt;
            byte_cnt <= byte_cnt_nxt;
            if (out_hs)
                word_idx <= (state == S_LEN_LO) ? 4'd0 : word_idx + 4'd1;
            if (in_hs)
                o_busy <= 1'b1;
            else if (state == S_LEN_LO && tready_m)
                o_busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sha1_msg_padder.sv
// Bench for sha1_msg_padder: byte-level padding model checked on every cycle,
// plus literal expectations for the classic SHA-1 padding boundary cases.
module tb_sha1_msg_padder;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        tvalid_s = 1'b0;
    logic [31:0] tdata_s = '0;
    logic [3:0]  tkeep_s = '0;
    logic        tlast_s = 1'b0;
    logic        tready_s;
    logic        tvalid_m;
    logic [31:0] tdata_m;
    logic        tlast_m;
    logic        tready_m = 1'b0;
    logic        o_busy;

    sha1_msg_padder #(.WIDTH(32), .BLK_WORDS(16), .CNT_W(61)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .tvalid_s(tvalid_s), .tdata_s(tdata_s), .tkeep_s(tkeep_s), .tlast_s(tlast_s),
        .tready_s(tready_s),
        .tvalid_m(tvalid_m), .tdata_m(tdata_m), .tlast_m(tlast_m), .tready_m(tready_m),
        .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model state
    logic [32:0] exp_q[$];
    logic [63:0] msg_bytes = 0;
    bit          pend = 0;
    bit          busy_exp = 0;
    bit          stall_v = 0;
    logic [31:0] stall_d = '0;
    logic [31:0] cap[8192];
    int          cap_n = 0;

    task automatic build_tail(input logic [31:0] d, input int k);
        logic [7:0]  b[$];
        logic [63:0] total;
        logic [63:0] len;
        logic [31:0] w;
        for (int i = 0; i < k; i++) b.push_back(d[31-8*i -: 8]);
        b.push_back(8'h80);
        total = msg_bytes + 64'(k) + 1;
        while (total % 64 != 56) begin
            b.push_back(8'h00);
            total++;
        end
        len = (msg_bytes + 64'(k)) * 8;
        for (int i = 0; i < 8; i++) b.push_back(len[63-8*i -: 8]);
        for (int i = 0; i < b.size(); i += 4) begin
            w = {b[i], b[i+1], b[i+2], b[i+3]};
            exp_q.push_back({(i + 4 == b.size()), w});
        end
    endtask

    initial begin
        logic [32:0] e;
        bit          busy_nxt;
        forever begin
            @(negedge i_clk);
            if (i_rst) begin
                chk("rst_tready_s", tready_s, 0);
                chk("rst_tvalid_m", tvalid_m, 0);
                chk("rst_tlast_m", tlast_m, 0);
                exp_q.delete();
                msg_bytes = 0;
                pend = 0;
                busy_exp = 0;
                stall_v = 0;
            end else begin
                chk("busy", o_busy, busy_exp);
                busy_nxt = busy_exp;
                if (stall_v) begin
                    chk("stall_valid", tvalid_m, 1);
                    chk("stall_data", tdata_m, stall_d);
                end
                if (pend) begin
                    chk("pad_tready_s", tready_s, 0);
                    chk("pad_tvalid_m", tvalid_m, 1);
                end else begin
                    chk("pass_tvalid_m", tvalid_m, tvalid_s && !(tlast_s && tkeep_s == 4'h0));
                    chk("pass_tready_s", tready_s, tready_m);
                end
                if (tvalid_s && tready_s) begin
                    busy_nxt = 1;
                    if (!tlast_s) begin
                        exp_q.push_back({1'b0, tdata_s});
                        msg_bytes += 4;
                    end else begin
                        build_tail(tdata_s, $countones(tkeep_s));
                        pend = 1;
                    end
                end
                if (tvalid_m && tready_m) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_word", {32'b0, tdata_m}, 64'hx);
                    end else begin
                        e = exp_q.pop_front();
                        chk("tdata_m", tdata_m, e[31:0]);
                        chk("tlast_m", tlast_m, e[32]);
                        cap[cap_n % 8192] = tdata_m;
                        cap_n++;
                        if (e[32]) begin
                            pend = 0;
                            msg_bytes = 0;
                            busy_nxt = 0;
                        end
                    end
                end
                stall_v = tvalid_m && !tready_m;
                stall_d = tdata_m;
                busy_exp = busy_nxt;
            end
        end
    end

    // Sink readiness: 0 random, 1 toggle, 2 always ready
    int rmode = 2;
    initial begin
        forever begin
            @(posedge i_clk);
            #1;
            case (rmode)
                0:       tready_m = ($urandom_range(0, 3) != 0);
                1:       tready_m = ~tready_m;
                default: tready_m = 1'b1;
            endcase
        end
    end

    logic [7:0] msg_buf[256];
    bit         gaps = 0;

    task automatic send(input int n, input bit etail);
        int full;
        int rem;
        int nw;
        int nb;
        int t;
        bit lastfull;
        logic [31:0] d;
        full = n / 4;
        rem = n % 4;
        lastfull = (rem == 0 && n > 0 && !etail);
        nw = lastfull ? full : full + 1;
        for (int w = 0; w < nw; w++) begin
            d = $urandom;
            nb = (w == nw - 1 && !lastfull) ? rem : 4;
            for (int b = 0; b < nb; b++) d[31-8*b -: 8] = msg_buf[4*w+b];
            if (gaps) repeat ($urandom_range(0, 2)) @(posedge i_clk);
            #1;
            tvalid_s = 1'b1;
            tdata_s  = d;
            tkeep_s  = (nb == 4) ? 4'hF : (nb == 3) ? 4'hE : (nb == 2) ? 4'hC : (nb == 1) ? 4'h8 : 4'h0;
            tlast_s  = (w == nw - 1);
            t = 0;
            do begin
                @(negedge i_clk);
                t++;
            end while (!tready_s && t < 1000);
            if (!tready_s) chk("accept_timeout", tready_s, 1);
            @(posedge i_clk);
            #1;
            tvalid_s = 1'b0;
            tlast_s  = 1'b0;
        end
    endtask

    task automatic drain;
        int t;
        t = 0;
        while ((pend || exp_q.size() != 0) && t < 2000) begin
            @(posedge i_clk);
            t++;
        end
        if (pend) chk("drain_timeout", tvalid_m, 0);
        @(posedge i_clk);
    endtask

    task automatic fill_rand(input int n);
        for (int i = 0; i < n; i++) msg_buf[i] = 8'($urandom);
    endtask

    int s;

    initial begin
        repeat (3) @(posedge i_clk);
        #1 i_rst = 1'b0;
        @(posedge i_clk);

        // "abc"
        msg_buf[0] = 8'h61; msg_buf[1] = 8'h62; msg_buf[2] = 8'h63;
        s = cap_n; send(3, 0); drain();
        chk("abc_count", 64'(cap_n - s), 16);
        chk("abc_w0", cap[s % 8192], 32'h6162_6380);
        chk("abc_w14", cap[(s+14) % 8192], 0);
        chk("abc_w15", cap[(s+15) % 8192], 32'h18);

        // empty message
        s = cap_n; send(0, 0); drain();
        chk("empty_count", 64'(cap_n - s), 16);
        chk("empty_w0", cap[s % 8192], 32'h8000_0000);
        chk("empty_w15", cap[(s+15) % 8192], 0);

        // 55 bytes: pad shares word 13
        fill_rand(55);
        s = cap_n; send(55, 0); drain();
        chk("b55_count", 64'(cap_n - s), 16);
        chk("b55_w13_pad", cap[(s+13) % 8192] & 32'hFF, 32'h80);
        chk("b55_w15", cap[(s+15) % 8192], 32'h1B8);

        // 56 bytes: spills into a second block
        fill_rand(56);
        s = cap_n; send(56, 0); drain();
        chk("b56_count", 64'(cap_n - s), 32);
        chk("b56_w14", cap[(s+14) % 8192], 32'h8000_0000);
        chk("b56_w15", cap[(s+15) % 8192], 0);
        chk("b56_w31", cap[(s+31) % 8192], 32'h1C0);

        // 52 bytes then empty tail: pad at 13, length straight after
        fill_rand(52);
        s = cap_n; send(52, 1); drain();
        chk("b52e_count", 64'(cap_n - s), 16);
        chk("b52e_w13", cap[(s+13) % 8192], 32'h8000_0000);
        chk("b52e_w15", cap[(s+15) % 8192], 32'h1A0);

        // 64 bytes with toggling sink
        rmode = 1;
        fill_rand(64);
        s = cap_n; send(64, 0); drain();
        chk("b64_count", 64'(cap_n - s), 32);
        chk("b64_w16", cap[(s+16) % 8192], 32'h8000_0000);
        chk("b64_w31", cap[(s+31) % 8192], 32'h200);
        rmode = 2;

        // reset while zero-filling a 20-byte message, then "abc"
        fill_rand(20);
        send(20, 0);
        repeat (3) @(posedge i_clk);
        #1 i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;
        @(posedge i_clk);
        msg_buf[0] = 8'h61; msg_buf[1] = 8'h62; msg_buf[2] = 8'h63;
        s = cap_n; send(3, 0); drain();
        chk("rst_abc_count", 64'(cap_n - s), 16);
        chk("rst_abc_w0", cap[s % 8192], 32'h6162_6380);
        chk("rst_abc_w15", cap[(s+15) % 8192], 32'h18);

        // randomized messages
        gaps = 1;
        for (int m = 0; m < 40; m++) begin
            int n;
            n = $urandom_range(0, 130);
            rmode = $urandom_range(0, 2);
            fill_rand(n);
            s = cap_n;
            send(n, ($urandom_range(0, 3) == 0));
            drain();
            chk("rand_blocks", 64'((cap_n - s) % 16), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $fatal(1);
    end

endmodule
